// File: rtl/mul_unit_seq.sv
// mul_unit_seq: radix-2 shift-add 64-bit multiplier for LEGv8 MUL / UMULH / SMULH.
// Operands come from the register file read ports, and the result goes back through a
// one-cycle write-back to the regfile write port. One product bit is retired per clock.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; operands are sampled on the accepting edge
// S_RUN  | WIDTH shift-add iterations, one per clock
// S_DONE | result and write-back presented for a single cycle
module mul_unit_seq #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    input  logic [ADDR_W-1:0] dest_add,
    output logic              busy,
    output logic              done,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_add,
    output logic [WIDTH-1:0]  wb_data
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] XZR      = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       m_q, m_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic                   neg_q, neg_d;
    logic                   hi_q, hi_d;
    logic [ADDR_W-1:0]      dest_q, dest_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   wb_en_q, wb_en_d;
    logic [ADDR_W-1:0]      wb_add_q, wb_add_d;
    logic [WIDTH-1:0]       wb_data_q, wb_data_d;

    logic                   a_neg, b_neg;
    logic [WIDTH-1:0]       a_mag, b_mag;
    logic [WIDTH-1:0]       addend;
    logic [WIDTH:0]         sum;
    logic [2*WIDTH-1:0]     acc_step;
    logic [2*WIDTH-1:0]     prod;
    logic                   last;

    // Operand conditioning and one shift-add step; the magnitude of the most negative
    // value is 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
    always_comb begin
        a_neg    = (op == 2'b10) && op_a[WIDTH-1];
        b_neg    = (op == 2'b10) && op_b[WIDTH-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        addend   = acc_q[0] ? m_q : {WIDTH{1'b0}};
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_step = {sum, acc_q[WIDTH-1:1]};
        prod     = neg_q ? -acc_step : acc_step;
        last     = (cnt_q == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; start is ignored outside IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: load on accept, iterate during RUN, hold otherwise.
    always_comb begin
        cnt_d  = cnt_q;
        m_d    = m_q;
        acc_d  = acc_q;
        neg_d  = neg_q;
        hi_d   = hi_q;
        dest_d = dest_q;
        if (state_q == S_IDLE && start) begin
            cnt_d  = '0;
            m_d    = a_mag;
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            neg_d  = a_neg ^ b_neg;
            hi_d   = (op == 2'b01) || (op == 2'b10);
            dest_d = dest_add;
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = acc_step;
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            m_q    <= '0;
            acc_q  <= '0;
            neg_q  <= 1'b0;
            hi_q   <= 1'b0;
            dest_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            m_q    <= m_d;
            acc_q  <= acc_d;
            neg_q  <= neg_d;
            hi_q   <= hi_d;
            dest_q <= dest_d;
        end
    end

    // Output next values; the result is formed from the final iteration on the DONE-entry edge.
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_q == S_RUN) && last;
        wb_en_d   = done_d && (dest_q != XZR);
        wb_add_d  = done_d ? dest_q : wb_add_q;
        wb_data_d = wb_data_q;
        if (done_d) wb_data_d = hi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    end

    // Output registers; write-back address and data hold after DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_add_q  <= '0;
            wb_data_q <= '0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            wb_en_q   <= wb_en_d;
            wb_add_q  <= wb_add_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wb_en   = wb_en_q;
    assign wb_add  = wb_add_q;
    assign wb_data = wb_data_q;

endmodule

// File: tb/tb_mul_unit_seq.sv
// tb_mul_unit_seq: directed tests for mul_unit_seq against a cycle-level reference model.
module tb_mul_unit_seq;

    localparam int WIDTH  = 64;
    localparam int ADDR_W = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [1:0]        op;
    logic [WIDTH-1:0]  op_a, op_b;
    logic [ADDR_W-1:0] dest_add;
    logic              busy, done, wb_en;
    logic [ADDR_W-1:0] wb_add;
    logic [WIDTH-1:0]  wb_data;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    mul_unit_seq #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .op_a(op_a), .op_b(op_b), .dest_add(dest_add),
        .busy(busy), .done(done), .wb_en(wb_en), .wb_add(wb_add), .wb_data(wb_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Architectural result of an operation, computed with full-width arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [63:0] a,
                                               input logic [63:0] b);
        logic [127:0]        u;
        logic signed [127:0] s;
        u = {64'b0, a} * {64'b0, b};
        s = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
        case (o)
            2'b01:   return u[127:64];
            2'b10:   return s[127:64];
            default: return u[63:0];
        endcase
    endfunction

    // Reference timeline: accept, result visible WIDTH edges later for one cycle, then idle.
    logic        m_busy, m_done, m_wben;
    logic [4:0]  m_add, p_add;
    logic [63:0] m_data, p_data;
    int          m_age;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_wben <= 1'b0;
            m_add  <= '0;   m_data <= '0;   m_age  <= 0;
            p_add  <= '0;   p_data <= '0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            m_wben <= 1'b0;
            if (start) begin
                m_busy <= 1'b1;
                m_age  <= 0;
                p_data <= ref_result(op, op_a, op_b);
                p_add  <= dest_add;
            end
        end else begin
            m_age <= m_age + 1;
            if (m_age + 1 == WIDTH) begin
                m_done <= 1'b1;
                m_wben <= (p_add != 5'd31);
                m_add  <= p_add;
                m_data <= p_data;
            end else if (m_age + 1 == WIDTH + 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
                m_wben <= 1'b0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (!reset) begin
            chk("busy",    64'(busy),    64'(m_busy));
            chk("done",    64'(done),    64'(m_done));
            chk("wb_en",   64'(wb_en),   64'(m_wben));
            chk("wb_add",  64'(wb_add),  64'(m_add));
            chk("wb_data", wb_data,      m_data);
            if (wb_en) wr_count++;
        end
    end

    // Waits for done; n counts edges from the accept edge (n0 already elapsed) through the done edge.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (n < 200) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (done) break;
        end
        chk("done timeout", 64'(done), 64'd1);
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp);
        int n;
        @(negedge clock);
        start = 1'b1; op = o; op_a = a; op_b = b; dest_add = rd;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        op_a = {$urandom, $urandom};
        op_b = {$urandom, $urandom};
        op = 2'($urandom);
        dest_add = 5'($urandom);
        wait_done(1, n);
        chk({name, " latency"}, 64'(n), 64'(WIDTH + 1));
        chk({name, " wb_en"},   64'(wb_en), (rd == 5'd31) ? 64'd0 : 64'd1);
        chk({name, " wb_add"},  64'(wb_add), 64'(rd));
        chk({name, " wb_data"}, wb_data, exp);
    endtask

    initial begin
        int n;
        int w0;
        reset = 1'b1; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0; dest_add = '0;
        repeat (3) @(negedge clock);
        chk("reset busy",    64'(busy),   64'd0);
        chk("reset done",    64'(done),   64'd0);
        chk("reset wb_en",   64'(wb_en),  64'd0);
        chk("reset wb_add",  64'(wb_add), 64'd0);
        chk("reset wb_data", wb_data,     64'd0);
        reset = 1'b0;

        run_op("mul 3*5",     2'b00, 64'd3, 64'd5, 5'd2, 64'd15);
        run_op("umulh max*2", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, 64'd1);
        run_op("mul max*2",   2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("smulh -1*1",  2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("smulh min*min", 2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               5'd10, 64'h4000_0000_0000_0000);
        run_op("mul op11 -3*5", 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd11,
               64'hFFFF_FFFF_FFFF_FFF1);
        run_op("smulh -3*5",  2'b10, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("umulh 0*max", 2'b01, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 64'd0);
        run_op("mul 7*6 xzr", 2'b00, 64'd7, 64'd6, 5'd31, 64'd42);

        // start held high; operands change at edge k+10 and must not affect the first result
        @(negedge clock);
        start = 1'b1; op = 2'b00; op_a = 64'd3; op_b = 64'd5; dest_add = 5'd4;
        @(posedge clock);
        repeat (9) @(posedge clock);
        @(negedge clock);
        op_a = 64'd100; op_b = 64'd7;
        wait_done(10, n);
        chk("held start latency", 64'(n), 64'(WIDTH + 1));
        chk("held start data", wb_data, 64'd15);
        @(posedge clock);
        @(negedge clock);
        chk("idle at k+65", 64'(busy), 64'd0);
        @(posedge clock);
        @(negedge clock);
        chk("second accept at k+66", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done(1, n);
        chk("second op latency", 64'(n), 64'(WIDTH + 1));
        chk("second op data", wb_data, 64'd700);

        // asynchronous reset during RUN aborts the operation
        @(negedge clock);
        start = 1'b1; op = 2'b00; op_a = 64'd9; op_b = 64'd9; dest_add = 5'd5;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (20) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("abort busy",    64'(busy),  64'd0);
        chk("abort done",    64'(done),  64'd0);
        chk("abort wb_en",   64'(wb_en), 64'd0);
        chk("abort wb_data", wb_data,    64'd0);
        w0 = wr_count;
        @(negedge clock);
        reset = 1'b0;
        repeat (80) @(negedge clock);
        chk("no write-back after abort", 64'(wr_count), 64'(w0));
        chk("idle after abort", 64'(busy), 64'd0);
        run_op("mul 2*2 after abort", 2'b00, 64'd2, 64'd2, 5'd6, 64'd4);

        @(negedge clock);
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
